// File: rtl/payload_loader_pkg.sv
// Shared definitions for the payload loader, the checksum stage and the top-level RAM mux.
package payload_loader_pkg;

  typedef enum logic [2:0] {
    IDLE,
    RECV,
    HANDOFF,
    WAIT_DONE,
    RELEASE
  } loader_state_e;

  // ram_sel polarity: the loader owns the RAM port when ram_sel is high.
  localparam logic RAM_SEL_LOADER   = 1'b1;
  localparam logic RAM_SEL_CHECKSUM = 1'b0;

  // Two words at the top of the RAM are reserved for the checksum.
  function automatic int calc_max_len(input int addr_bits);
    return (2 ** addr_bits) - 2;
  endfunction

endpackage

// File: rtl/payload_loader.sv
// Stream-to-RAM frame loader: stores one frame's payload, then lends the RAM to the checksum stage.
module payload_loader
  import payload_loader_pkg::*;
#(
  parameter int RAM_WIDTH     = 8,
  parameter int RAM_ADDR_BITS = 8,
  parameter int MAX_LEN       = calc_max_len(RAM_ADDR_BITS)
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [RAM_WIDTH-1:0]     in_data,
  input  logic                     in_valid,
  input  logic                     in_last,
  output logic                     in_ready,
  output logic                     write_enable,
  output logic [RAM_ADDR_BITS-1:0] address,
  output logic [RAM_WIDTH-1:0]     mem_input,
  output logic                     ram_sel,
  output logic [15:0]              payload_len,
  output logic                     mem_ready,
  input  logic                     work_complete,
  output logic                     overflow
);

  // One extra count bit so reaching MAX_LEN can never wrap the address.
  localparam int               CW        = RAM_ADDR_BITS + 1;
  localparam logic [CW-1:0]    MAX_LEN_C = CW'(MAX_LEN);

  loader_state_e            state_q, state_d;
  logic [CW-1:0]            count_q, count_d;
  logic                     write_enable_q, write_enable_d;
  logic [RAM_ADDR_BITS-1:0] address_q, address_d;
  logic [RAM_WIDTH-1:0]     mem_input_q, mem_input_d;
  logic                     ram_sel_q, ram_sel_d;
  logic [15:0]              payload_len_q, payload_len_d;
  logic                     mem_ready_q, mem_ready_d;
  logic                     overflow_q, overflow_d;

  logic                     accepting;
  logic                     beat;
  logic [CW-1:0]            base_count;
  logic                     base_overflow;

  assign accepting = !reset && ((state_q == IDLE) || (state_q == RECV));
  assign beat      = in_valid && accepting;

  always_comb begin
    state_d        = state_q;
    count_d        = count_q;
    write_enable_d = 1'b0;
    address_d      = address_q;
    mem_input_d    = mem_input_q;
    ram_sel_d      = ram_sel_q;
    payload_len_d  = payload_len_q;
    mem_ready_d    = mem_ready_q;
    overflow_d     = overflow_q;

    // The first beat of a frame starts from a clean count and overflow flag.
    base_count     = (state_q == IDLE) ? '0 : count_q;
    base_overflow  = (state_q == IDLE) ? 1'b0 : overflow_q;

    unique case (state_q)
      IDLE, RECV: begin
        if (beat) begin
          count_d    = base_count;
          overflow_d = base_overflow;
          if (base_count < MAX_LEN_C) begin
            write_enable_d = 1'b1;
            address_d      = base_count[RAM_ADDR_BITS-1:0];
            mem_input_d    = in_data;
            count_d        = base_count + CW'(1);
          end else begin
            overflow_d = 1'b1;
          end
          if (in_last) begin
            payload_len_d = 16'(count_d);
            state_d       = HANDOFF;
          end else begin
            state_d = RECV;
          end
        end
      end
      HANDOFF: begin
        address_d   = '0;
        ram_sel_d   = RAM_SEL_CHECKSUM;
        mem_ready_d = 1'b1;
        state_d     = WAIT_DONE;
      end
      WAIT_DONE: begin
        if (work_complete) begin
          mem_ready_d = 1'b0;
          state_d     = RELEASE;
        end
      end
      RELEASE: begin
        // Hold off one cycle so the checksum stage's final write lands first.
        ram_sel_d = RAM_SEL_LOADER;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q        <= IDLE;
      count_q        <= '0;
      write_enable_q <= 1'b0;
      address_q      <= '0;
      mem_input_q    <= '0;
      ram_sel_q      <= RAM_SEL_LOADER;
      payload_len_q  <= '0;
      mem_ready_q    <= 1'b0;
      overflow_q     <= 1'b0;
    end else begin
      state_q        <= state_d;
      count_q        <= count_d;
      write_enable_q <= write_enable_d;
      address_q      <= address_d;
      mem_input_q    <= mem_input_d;
      ram_sel_q      <= ram_sel_d;
      payload_len_q  <= payload_len_d;
      mem_ready_q    <= mem_ready_d;
      overflow_q     <= overflow_d;
    end
  end

  assign in_ready     = accepting;
  assign write_enable = write_enable_q;
  assign address      = address_q;
  assign mem_input    = mem_input_q;
  assign ram_sel      = ram_sel_q;
  assign payload_len  = payload_len_q;
  assign mem_ready    = mem_ready_q;
  assign overflow     = overflow_q;

endmodule

// File: tb/tb_payload_loader.sv
// Scoreboard bench for payload_loader: stimulus queues expected RAM writes and frame results, a monitor checks them.
module tb_payload_loader;

  logic        clock = 1'b0;
  logic        reset;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_last;
  logic        in_ready;
  logic        write_enable;
  logic [7:0]  address;
  logic [7:0]  mem_input;
  logic        ram_sel;
  logic [15:0] payload_len;
  logic        mem_ready;
  logic        work_complete;
  logic        overflow;

  int checks = 0;
  int errors = 0;

  logic [15:0] wr_q[$];   // {address, data}
  logic [16:0] fr_q[$];   // {overflow, payload_len}
  logic        mr_prev = 1'b0;

  payload_loader dut (
    .clock         (clock),
    .reset         (reset),
    .in_data       (in_data),
    .in_valid      (in_valid),
    .in_last       (in_last),
    .in_ready      (in_ready),
    .write_enable  (write_enable),
    .address       (address),
    .mem_input     (mem_input),
    .ram_sel       (ram_sel),
    .payload_len   (payload_len),
    .mem_ready     (mem_ready),
    .work_complete (work_complete),
    .overflow      (overflow)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Monitor: every RAM write and every mem_ready rise must match the next queued expectation.
  always @(negedge clock) begin
    logic [15:0] w;
    logic [16:0] f;
    if (write_enable === 1'b1) begin
      if (wr_q.size() == 0) begin
        check("unexpected_write", {16'h0, address, mem_input}, 32'hFFFF_FFFF);
      end else begin
        w = wr_q.pop_front();
        $display("write addr=%0d data=%02h", address, mem_input);
        check("write_addr_data", {16'h0, address, mem_input}, {16'h0, w});
        check("write_ram_sel", {31'h0, ram_sel}, 32'h1);
      end
    end
    if (mem_ready === 1'b1 && mr_prev === 1'b0) begin
      if (fr_q.size() == 0) begin
        check("unexpected_mem_ready", {15'h0, overflow, payload_len}, 32'hFFFF_FFFF);
      end else begin
        f = fr_q.pop_front();
        $display("frame payload_len=%0d overflow=%0d", payload_len, overflow);
        check("frame_len_ovf", {15'h0, overflow, payload_len}, {15'h0, f});
        check("frame_ram_sel", {31'h0, ram_sel}, 32'h0);
      end
    end
    mr_prev = mem_ready;
  end

  task automatic send(input logic [7:0] d, input logic last, input logic exp_wr,
                      input logic [7:0] exp_addr, output int stalls);
    int n;
    if (exp_wr) wr_q.push_back({exp_addr, d});
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
    n = 0;
    do begin
      @(negedge clock);
      n++;
    end while (!in_ready && n < 50);
    stalls = n - 1;
    if (!in_ready) begin
      check("send_timeout", 32'h0, 32'h1);
      in_valid = 1'b0;
      in_last  = 1'b0;
      return;
    end
    @(posedge clock);
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic wait_mem_ready(input string name);
    int n = 0;
    do begin
      @(negedge clock);
      n++;
    end while (mem_ready !== 1'b1 && n < 20);
    check(name, n, 2);
  endtask

  task automatic handshake();
    @(posedge clock);
    #1;
    work_complete = 1'b1;
    @(posedge clock);
    #1;
    work_complete = 1'b0;
    check("wc_mem_ready_fall", {31'h0, mem_ready}, 32'h0);
    check("wc_release_ram_sel", {31'h0, ram_sel}, 32'h0);
    check("wc_release_in_ready", {31'h0, in_ready}, 32'h0);
    @(posedge clock);
    #1;
    check("wc_ram_sel_back", {31'h0, ram_sel}, 32'h1);
    check("wc_in_ready_back", {31'h0, in_ready}, 32'h1);
  endtask

  task automatic check_reset_values();
    check("rst_in_ready", {31'h0, in_ready}, 32'h0);
    check("rst_write_enable", {31'h0, write_enable}, 32'h0);
    check("rst_address", {24'h0, address}, 32'h0);
    check("rst_mem_input", {24'h0, mem_input}, 32'h0);
    check("rst_ram_sel", {31'h0, ram_sel}, 32'h1);
    check("rst_payload_len", {16'h0, payload_len}, 32'h0);
    check("rst_mem_ready", {31'h0, mem_ready}, 32'h0);
    check("rst_overflow", {31'h0, overflow}, 32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int st;
    int stall_total;
    reset         = 1'b1;
    in_data       = 8'h00;
    in_valid      = 1'b0;
    in_last       = 1'b0;
    work_complete = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    check_reset_values();
    reset = 1'b0;
    @(negedge clock);
    check("idle_in_ready", {31'h0, in_ready}, 32'h1);

    // Stray work_complete in IDLE
    @(posedge clock);
    #1;
    work_complete = 1'b1;
    @(posedge clock);
    #1;
    work_complete = 1'b0;
    check("stray_idle_mem_ready", {31'h0, mem_ready}, 32'h0);
    check("stray_idle_in_ready", {31'h0, in_ready}, 32'h1);

    // 5-byte frame with a stray work_complete in RECV, then bytes offered during WAIT_DONE
    send(8'h01, 1'b0, 1'b1, 8'd0, st);
    send(8'h02, 1'b0, 1'b1, 8'd1, st);
    work_complete = 1'b1;
    @(posedge clock);
    #1;
    work_complete = 1'b0;
    check("stray_recv_in_ready", {31'h0, in_ready}, 32'h1);
    check("stray_recv_mem_ready", {31'h0, mem_ready}, 32'h0);
    send(8'h03, 1'b0, 1'b1, 8'd2, st);
    send(8'h04, 1'b0, 1'b1, 8'd3, st);
    fr_q.push_back({1'b0, 16'd5});
    send(8'h05, 1'b1, 1'b1, 8'd4, st);
    check("last_in_ready_low", {31'h0, in_ready}, 32'h0);
    wait_mem_ready("f5_mem_ready_latency");
    in_valid = 1'b1;
    in_data  = 8'hEE;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      check("wait_done_in_ready", {31'h0, in_ready}, 32'h0);
    end
    in_valid = 1'b0;
    handshake();

    // Single-byte frame
    fr_q.push_back({1'b0, 16'd1});
    send(8'hAA, 1'b1, 1'b1, 8'd0, st);
    check("single_in_ready_low", {31'h0, in_ready}, 32'h0);
    wait_mem_ready("f1_mem_ready_latency");
    handshake();

    // 4-byte frame with in_valid toggling
    fr_q.push_back({1'b0, 16'd4});
    for (int i = 0; i < 4; i++) begin
      logic [7:0] d;
      d = 8'h10 + 8'(i);
      send(d, (i == 3), 1'b1, 8'(i), st);
      if (i != 3) begin
        @(posedge clock);
        #1;
      end
    end
    wait_mem_ready("f4_mem_ready_latency");
    handshake();

    // 260-byte frame: 254 stored, rest discarded with overflow
    stall_total = 0;
    fr_q.push_back({1'b1, 16'd254});
    for (int i = 0; i < 260; i++) begin
      send(8'(i), (i == 259), (i < 254), 8'(i), st);
      stall_total += st;
    end
    check("ovf_no_stall", stall_total, 0);
    wait_mem_ready("f260_mem_ready_latency");
    check("ovf_flag_set", {31'h0, overflow}, 32'h1);
    handshake();
    fr_q.push_back({1'b0, 16'd2});
    send(8'h11, 1'b0, 1'b1, 8'd0, st);
    check("ovf_clear_first_beat", {31'h0, overflow}, 32'h0);
    send(8'h22, 1'b1, 1'b1, 8'd1, st);
    wait_mem_ready("f2_mem_ready_latency");
    handshake();

    // Reset mid-RECV after 3 bytes, then a 2-byte frame
    send(8'h51, 1'b0, 1'b1, 8'd0, st);
    send(8'h52, 1'b0, 1'b1, 8'd1, st);
    send(8'h53, 1'b0, 1'b1, 8'd2, st);
    reset = 1'b1;
    repeat (2) begin
      @(posedge clock);
      #1;
      check_reset_values();
    end
    reset = 1'b0;
    fr_q.push_back({1'b0, 16'd2});
    send(8'h33, 1'b0, 1'b1, 8'd0, st);
    send(8'h44, 1'b1, 1'b1, 8'd1, st);
    wait_mem_ready("post_reset_mem_ready_latency");
    check("post_reset_payload_len", {16'h0, payload_len}, 32'd2);
    handshake();

    repeat (3) @(posedge clock);
    #1;
    check("writes_outstanding", wr_q.size(), 0);
    check("frames_outstanding", fr_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
